cache_arbiter: RTL
==================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter TMO, default 64, giving the maximum number of cycles to wait for c_done per transaction; the legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports rq0_rd and rq0_wr, input, 1 bit each: read and write request from requester 0 (instruction side).
REQ-005 The block SHALL have ports rq0_addr and rq0_wdata, input, 16 bits each: address and write data from requester 0.
REQ-006 The block SHALL have ports rq0_rdata, output, 16 bits, and rq0_done, rq0_stall and rq0_err, output, 1 bit each: response to requester 0.
REQ-007 The block SHALL have ports rq1_rd, rq1_wr, rq1_addr, rq1_wdata, rq1_rdata, rq1_done, rq1_stall and rq1_err for requester 1 (data side), with the same widths as requester 0.
REQ-008 The block SHALL have ports c_rd and c_wr, output, 1 bit each, and c_addr and c_wdata, output, 16 bits each: the command to the cache controller.
REQ-009 The block SHALL have ports c_rdata, input, 16 bits, and c_done, c_hit and c_err, input, 1 bit each: the cache response.
REQ-010 The block SHALL have ports acc_cnt and hit_cnt, output, 16 bits each: counts of completed accesses and of hits.

Function
REQ-011 The block SHALL implement the states IDLE, BUSY, RESP and FAULT, encoded in 2 bits.
REQ-012 A requester SHALL be pending when its rd or wr is 1; each requester holds rd, wr, addr and wdata stable until it sees its done or err.
REQ-013 In IDLE, if exactly one requester is pending, it SHALL be granted.
REQ-014 In IDLE, if both requesters are pending, the requester not granted most recently SHALL be granted (round-robin); the last-grant register updates on every grant.
REQ-015 On grant, the block SHALL capture rd, wr, addr and wdata into command registers and go to BUSY on the next edge.
REQ-016 A granted requester with rd=wr=1 SHALL skip the cache entirely: the block goes directly to RESP with err=1 and does not count the access.
REQ-017 In BUSY, c_rd, c_wr, c_addr and c_wdata SHALL be driven from the command registers on every cycle; in all other states c_rd and c_wr are 0.
REQ-018 In BUSY, a 16-bit counter SHALL count cycles from 1; on c_done=1 the block SHALL capture c_rdata, c_hit and c_err and go to RESP.
REQ-019 If the BUSY counter reaches TMO without c_done, the block SHALL go to FAULT.
REQ-020 RESP SHALL last exactly 1 cycle, during which the granted requester's done=1, its rdata equals the captured data and its err equals the captured c_err; the next state is IDLE.
REQ-021 rqN_done SHALL be a single-cycle pulse; rqN_rdata SHALL hold its last value outside RESP.
REQ-022 rqN_stall SHALL be 1 while requester N is pending and the state is not RESP-for-N; otherwise it is 0.
REQ-023 Latency SHALL be as follows: a request pending in IDLE at cycle t drives c_rd/c_wr at t+1; c_done at cycle m gives done at m+1 and IDLE at m+2. The minimum request-to-done latency is 3 cycles.
REQ-024 A request dropped mid-transaction SHALL NOT abort the cache access; the done pulse is still generated.
REQ-025 FAULT SHALL be sticky until rst: c_rd=c_wr=0, rq0_err=rq1_err=1, both stall outputs follow REQ-022, and no done pulses are produced.
REQ-026 On each RESP that follows c_done, acc_cnt SHALL increment by 1, and hit_cnt SHALL also increment by 1 if the captured c_hit=1; both counters wrap from 0xFFFF to 0x0000.
REQ-027 c_done, c_hit and c_err SHALL be ignored outside BUSY.

Reset
REQ-028 When rst=1 at an edge, the block SHALL enter IDLE and clear the last-grant register to 1, so requester 0 wins the first tie; this applies in any state, including BUSY and FAULT.
REQ-029 The reset SHALL clear the BUSY counter, the command registers, rq0_rdata, rq1_rdata, acc_cnt and hit_cnt to 0.
REQ-030 During and after reset, all done, stall, err, c_rd and c_wr outputs SHALL be 0 until a new request is seen.
REQ-031 A reset during BUSY SHALL drop c_rd and c_wr on the following cycle and produce no done pulse.

Verification
REQ-032 The bench SHALL cover a single read: rq0_rd=1, addr=0x1234; cache c_done=1, c_hit=1, c_rdata=0xBEEF, 2 cycles after c_rd -> rq0_done pulse 1 cycle later with rq0_rdata=0xBEEF, acc_cnt=1, hit_cnt=1.
REQ-033 The bench SHALL cover contention: rq0 and rq1 both pending from reset -> rq0 served first, then rq1, then rq0 again on a re-request; rq1_stall=1 throughout rq0's transaction.
REQ-034 The bench SHALL cover an illegal op: rq1_rd=rq1_wr=1 -> c_rd=c_wr=0, rq1_done=1 and rq1_err=1 two cycles after the request, acc_cnt unchanged.
REQ-035 The bench SHALL cover a timeout: TMO=64 and c_done never asserted -> FAULT after 64 BUSY cycles, both err outputs=1, sticky; then rst=1 -> IDLE with all outputs 0.
REQ-036 The bench SHALL cover a miss write: rq1_wr=1, wdata=0x00AA, c_done after 20 cycles with c_hit=0 -> c_wdata=0x00AA held for all 20 cycles, rq1_done pulse, hit_cnt unchanged.
REQ-037 The bench SHALL cover counter wrap: acc_cnt preloaded via 65535 accesses, one more access -> acc_cnt=0x0000.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one cache controller between an instruction
// and a data requester, with per-transaction timeout and access/hit statistics.
module cache_arbiter #(
    parameter int TMO = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rq0_rd,
    input  logic        rq0_wr,
    input  logic [15:0] rq0_addr,
    input  logic [15:0] rq0_wdata,
    output logic [15:0] rq0_rdata,
    output logic        rq0_done,
    output logic        rq0_stall,
    output logic        rq0_err,
    input  logic        rq1_rd,
    input  logic        rq1_wr,
    input  logic [15:0] rq1_addr,
    input  logic [15:0] rq1_wdata,
    output logic [15:0] rq1_rdata,
    output logic        rq1_done,
    output logic        rq1_stall,
    output logic        rq1_err,
    output logic        c_rd,
    output logic        c_wr,
    output logic [15:0] c_addr,
    output logic [15:0] c_wdata,
    input  logic [15:0] c_rdata,
    input  logic        c_done,
    input  logic        c_hit,
    input  logic        c_err,
    output logic [15:0] acc_cnt,
    output logic [15:0] hit_cnt
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP, FAULT} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, gnt_q, gnt_d, err_q, err_d;
    logic cmd_rd_q, cmd_rd_d, cmd_wr_q, cmd_wr_d;
    logic [15:0] cmd_addr_q, cmd_addr_d, cmd_wdata_q, cmd_wdata_d, cnt_q, cnt_d;
    logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [15:0] acc_cnt_q, acc_cnt_d, hit_cnt_q, hit_cnt_d;
    logic pend0, pend1, sel, g_rd, g_wr, resp0, resp1, fault;
    assign pend0 = rq0_rd | rq0_wr;
    assign pend1 = rq1_rd | rq1_wr;
    // sel=1 grants requester 1; on a tie the one not granted last wins
    assign sel = (pend0 && pend1) ? !last_q : pend1;
    assign g_rd = sel ? rq1_rd : rq0_rd;
    assign g_wr = sel ? rq1_wr : rq0_wr;
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        err_d       = err_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cnt_d       = cnt_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        acc_cnt_d   = acc_cnt_q;
        hit_cnt_d   = hit_cnt_q;
        case (state_q)
            IDLE: if (pend0 || pend1) begin
                gnt_d       = sel;
                last_d      = sel;
                cmd_rd_d    = g_rd;
                cmd_wr_d    = g_wr;
                cmd_addr_d  = sel ? rq1_addr : rq0_addr;
                cmd_wdata_d = sel ? rq1_wdata : rq0_wdata;
                cnt_d       = 16'd1;
                err_d       = g_rd && g_wr;
                state_d     = (g_rd && g_wr) ? RESP : BUSY;
            end
            BUSY: if (c_done) begin
                state_d   = RESP;
                err_d     = c_err;
                rdata0_d  = gnt_q ? rdata0_q : c_rdata;
                rdata1_d  = gnt_q ? c_rdata : rdata1_q;
                acc_cnt_d = acc_cnt_q + 16'd1;
                hit_cnt_d = hit_cnt_q + {15'd0, c_hit};
            end else if (cnt_q == 16'(TMO)) begin
                state_d = FAULT;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = FAULT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            err_q       <= 1'b0;
            cmd_rd_q    <= 1'b0;
            cmd_wr_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            acc_cnt_q   <= '0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            err_q       <= err_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cnt_q       <= cnt_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            acc_cnt_q   <= acc_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end
    assign resp0     = (state_q == RESP) && !gnt_q;
    assign resp1     = (state_q == RESP) && gnt_q;
    assign fault     = state_q == FAULT;
    assign c_rd      = (state_q == BUSY) && cmd_rd_q;
    assign c_wr      = (state_q == BUSY) && cmd_wr_q;
    assign c_addr    = cmd_addr_q;
    assign c_wdata   = cmd_wdata_q;
    assign rq0_done  = resp0;
    assign rq1_done  = resp1;
    assign rq0_err   = (resp0 && err_q) || fault;
    assign rq1_err   = (resp1 && err_q) || fault;
    // stall is held low while reset is applied so the requesters see a quiet bus
    assign rq0_stall = pend0 && !resp0 && !rst;
    assign rq1_stall = pend1 && !resp1 && !rst;
    assign rq0_rdata = rdata0_q;
    assign rq1_rdata = rdata1_q;
    assign acc_cnt   = acc_cnt_q;
    assign hit_cnt   = hit_cnt_q;
endmodule
